// File: rtl/ldiv_pkg.sv
// Shared constants and helpers for the ldiv scheduler and its divider.
package ldiv_pkg;

  // Divider pipeline depth: one operand-capture stage plus one stage per numerator bit.
  function automatic int unsigned ldiv_latency(int unsigned numerator_width);
    return numerator_width + 1;
  endfunction

  // Requester ID width, never narrower than one bit.
  function automatic int unsigned ldiv_id_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Result tag layout, LSB first: valid, divide-by-zero, then the requester ID.
  localparam int unsigned TagValidBit = 0;
  localparam int unsigned TagDbzBit   = 1;
  localparam int unsigned TagIdLsb    = 2;

  function automatic int unsigned ldiv_tag_width(int unsigned id_width);
    return TagIdLsb + id_width;
  endfunction

endpackage

// File: rtl/ldiv.sv
// Fully pipelined restoring long divider, one result per cycle, latency NUMERATOR_WIDTH+1.
// Denominator 0 yields quotient all-ones and remainder equal to the numerator.
module ldiv #(
  parameter int unsigned NUMERATOR_WIDTH   = 24,
  parameter int unsigned DENOMINATOR_WIDTH = 20,
  parameter int unsigned QUOTIENT_WIDTH    = NUMERATOR_WIDTH
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         valid_in,
  input  logic [NUMERATOR_WIDTH-1:0]   numerator_in,
  input  logic [DENOMINATOR_WIDTH-1:0] denominator_in,
  output logic                         valid_out,
  output logic [QUOTIENT_WIDTH-1:0]    quotient_out,
  output logic [NUMERATOR_WIDTH-1:0]   remainder_out
);

  localparam int unsigned NW = NUMERATOR_WIDTH;
  localparam int unsigned DW = DENOMINATOR_WIDTH;

  // Each stage word is {partial remainder, numerator bits still to consume / quotient bits so far}.
  logic [2*NW-1:0] work_q [NW+1];
  logic [2*NW-1:0] work_d [NW+1];
  logic [DW-1:0]   den_q  [NW];
  logic [DW-1:0]   den_d  [NW];
  logic [NW:0]     vld_q, vld_d;

  // One shift-compare-subtract step per stage.
  always_comb begin
    logic [2*NW:0] shifted;
    logic [NW:0]   trial;
    shifted = '0;
    trial   = '0;
    vld_d   = '0;
    for (int k = 0; k <= NW; k++) work_d[k] = '0;
    for (int k = 0; k < NW; k++) den_d[k] = '0;

    work_d[0] = {{NW{1'b0}}, numerator_in};
    den_d[0]  = denominator_in;
    vld_d[0]  = valid_in;
    for (int k = 0; k < NW; k++) begin
      shifted     = {work_q[k], 1'b0};
      trial       = shifted[2*NW:NW];
      vld_d[k+1]  = vld_q[k];
      if (k + 1 < NW) den_d[k+1] = den_q[k];
      if (trial >= (NW+1)'(den_q[k])) begin
        work_d[k+1] = {NW'(trial - (NW+1)'(den_q[k])), shifted[NW-1:1], 1'b1};
      end else begin
        // Top bit is zero here because the partial remainder is below the denominator.
        work_d[k+1] = shifted[2*NW-1:0];
      end
    end
  end

  // Pipeline registers; reset drops every operation in flight.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld_q <= '0;
      for (int k = 0; k <= NW; k++) work_q[k] <= '0;
      for (int k = 0; k < NW; k++) den_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      work_q <= work_d;
      den_q  <= den_d;
    end
  end

  assign valid_out     = vld_q[NW];
  assign quotient_out  = QUOTIENT_WIDTH'(work_q[NW][NW-1:0]);
  assign remainder_out = work_q[NW][2*NW-1:NW];

endmodule

// File: rtl/ldiv_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr.
module ldiv_rr_arb #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldiv_sched.sv
// Round-robin scheduler sharing one pipelined ldiv among NUM_REQ requesters, with
// per-requester in-flight credits and an ID/dbz tag pipeline aligned to the divider.
module ldiv_sched
  import ldiv_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned NUMERATOR_WIDTH   = 24,
  parameter int unsigned DENOMINATOR_WIDTH = 20,
  parameter int unsigned QUOTIENT_WIDTH    = 24,
  parameter int unsigned MAX_INFLIGHT      = 4,
  localparam int unsigned ID_WIDTH         = ldiv_id_width(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 resetb,
  input  logic                                 issue_en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*NUMERATOR_WIDTH-1:0]   req_numerator,
  input  logic [NUM_REQ*DENOMINATOR_WIDTH-1:0] req_denominator,
  output logic                                 res_valid,
  output logic [ID_WIDTH-1:0]                  res_id,
  output logic [QUOTIENT_WIDTH-1:0]            res_quotient,
  output logic [NUMERATOR_WIDTH-1:0]           res_remainder,
  output logic                                 res_div_by_zero,
  output logic                                 busy
);

  localparam int unsigned LATENCY = ldiv_latency(NUMERATOR_WIDTH);
  localparam int unsigned TAG_W   = ldiv_tag_width(ID_WIDTH);
  localparam int unsigned CNT_W   = $clog2(MAX_INFLIGHT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [ID_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  cnt_t                         inflight_q [NUM_REQ];
  cnt_t                         inflight_d [NUM_REQ];
  logic [TAG_W-1:0]             tag_q [LATENCY];
  logic [TAG_W-1:0]             tag_d [LATENCY];
  logic [TAG_W-1:0]             tag_out;

  logic [NUM_REQ-1:0]           eligible;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_WIDTH-1:0]          grant_idx;
  logic                         grant_any;
  logic                         xfer;
  logic [NUMERATOR_WIDTH-1:0]   issue_num;
  logic [DENOMINATOR_WIDTH-1:0] issue_den;
  logic                         issue_dbz;
  logic                         div_valid;
  logic [QUOTIENT_WIDTH-1:0]    div_quo;
  logic [NUMERATOR_WIDTH-1:0]   div_rem;

  // Eligibility: pending request, spare credit, issue enabled; nothing granted under reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = resetb & issue_en & req_valid[i] & (inflight_q[i] < cnt_t'(MAX_INFLIGHT));
    end
  end

  ldiv_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  // A grant always lands on a valid requester, so any grant is a transfer.
  assign xfer      = grant_any;

  // Mux the granted requester's operands onto the divider.
  always_comb begin
    issue_num = req_numerator[32'(grant_idx) * NUMERATOR_WIDTH +: NUMERATOR_WIDTH];
    issue_den = req_denominator[32'(grant_idx) * DENOMINATOR_WIDTH +: DENOMINATOR_WIDTH];
    issue_dbz = xfer & (issue_den == '0);
  end

  ldiv #(
    .NUMERATOR_WIDTH   (NUMERATOR_WIDTH),
    .DENOMINATOR_WIDTH (DENOMINATOR_WIDTH),
    .QUOTIENT_WIDTH    (QUOTIENT_WIDTH)
  ) u_ldiv (
    .clk            (clk),
    .resetb         (resetb),
    .valid_in       (xfer),
    .numerator_in   (issue_num),
    .denominator_in (issue_den),
    .valid_out      (div_valid),
    .quotient_out   (div_quo),
    .remainder_out  (div_rem)
  );

  // Tag shift register running in lockstep with the divider pipeline.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) tag_d[k] = '0;
    tag_d[0][TagValidBit]            = xfer;
    tag_d[0][TagDbzBit]              = issue_dbz;
    tag_d[0][TagIdLsb +: ID_WIDTH]   = grant_idx;
    for (int k = 1; k < LATENCY; k++) tag_d[k] = tag_q[k-1];
  end

  assign tag_out         = tag_q[LATENCY-1];
  assign res_valid       = tag_out[TagValidBit] & div_valid;
  assign res_id          = tag_out[TagIdLsb +: ID_WIDTH];
  assign res_div_by_zero = tag_out[TagDbzBit] & res_valid;
  assign res_quotient    = div_quo;
  assign res_remainder   = div_rem;

  // Credit counters and round-robin pointer next state.
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inflight_d[i] = inflight_q[i];
      inc = xfer & grant[i];
      dec = res_valid & (res_id == ID_WIDTH'(i));
      if (inc && !dec) begin
        inflight_d[i] = inflight_q[i] + cnt_t'(1);
      end else if (dec && !inc) begin
        inflight_d[i] = inflight_q[i] - cnt_t'(1);
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  // Busy while any requester has work outstanding.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) busy = busy | (inflight_q[i] != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) inflight_q[i] <= '0;
      for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_ldiv_sched.sv
// Scoreboard bench for ldiv_sched: a cycle model predicts grants and pushes hand-computed
// results; a negedge monitor compares grants, busy and every returned result.
module tb_ldiv_sched;

  localparam int NR   = 4;
  localparam int NW   = 24;
  localparam int DW   = 20;
  localparam int LAT  = 25;
  localparam int MAXF = 4;
  localparam int SBD  = 1024;

  logic             clk;
  logic             resetb;
  logic             issue_en;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*NW-1:0] req_numerator;
  logic [NR*DW-1:0] req_denominator;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [NW-1:0]    res_quotient;
  logic [NW-1:0]    res_remainder;
  logic             res_div_by_zero;
  logic             busy;

  ldiv_sched #(
    .NUM_REQ           (NR),
    .NUMERATOR_WIDTH   (NW),
    .DENOMINATOR_WIDTH (DW),
    .QUOTIENT_WIDTH    (NW),
    .MAX_INFLIGHT      (MAXF)
  ) dut (
    .clk             (clk),
    .resetb          (resetb),
    .issue_en        (issue_en),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_numerator   (req_numerator),
    .req_denominator (req_denominator),
    .res_valid       (res_valid),
    .res_id          (res_id),
    .res_quotient    (res_quotient),
    .res_remainder   (res_remainder),
    .res_div_by_zero (res_div_by_zero),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed expectations for each requester's current operands (stimulus-owned).
  logic [NW-1:0] op_q   [NR];
  logic [NW-1:0] op_r   [NR];
  logic          op_dbz [NR];

  // Model state (model process only).
  int            cyc;
  int            m_ptr;
  int            m_infl  [NR];
  int            ret_id  [SBD];
  int            ret_due [SBD];
  int            ret_wr, ret_rd;
  int            sb_id   [SBD];
  int            sb_due  [SBD];
  logic [NW-1:0] sb_q    [SBD];
  logic [NW-1:0] sb_r    [SBD];
  logic          sb_dbz  [SBD];
  int            sb_wr;

  // Monitor state (monitor process only).
  int   sb_rd;
  int   n_checks, n_errors;
  logic fin;

  // Stimulus-owned handshake.
  logic done;

  function automatic int pick();
    int r;
    int i;
    r = -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (r < 0 && resetb && issue_en && req_valid[i] && m_infl[i] < MAXF) r = i;
    end
    return r;
  endfunction

  // Cycle model: predicts each accept, schedules its result LAT cycles later.
  initial begin
    int g;
    cyc = 0; m_ptr = 0; ret_wr = 0; ret_rd = 0; sb_wr = 0;
    for (int i = 0; i < NR; i++) m_infl[i] = 0;
    forever begin
      @(posedge clk);
      if (!resetb) begin
        m_ptr = 0;
        for (int i = 0; i < NR; i++) m_infl[i] = 0;
        ret_rd = ret_wr;
      end else begin
        g = pick();
        if (ret_rd != ret_wr && ret_due[ret_rd % SBD] == cyc) begin
          m_infl[ret_id[ret_rd % SBD]]--;
          ret_rd++;
        end
        if (g >= 0) begin
          sb_id[sb_wr % SBD]  = g;
          sb_due[sb_wr % SBD] = cyc + LAT;
          sb_q[sb_wr % SBD]   = op_q[g];
          sb_r[sb_wr % SBD]   = op_r[g];
          sb_dbz[sb_wr % SBD] = op_dbz[g];
          sb_wr++;
          ret_id[ret_wr % SBD]  = g;
          ret_due[ret_wr % SBD] = cyc + LAT;
          ret_wr++;
          m_infl[g]++;
          m_ptr = (g + 1) % NR;
        end
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares grants, busy and results away from the active edge.
  initial begin
    int         g;
    logic       exp_v;
    logic       exp_busy;
    logic [NR-1:0] exp_rdy;
    sb_rd = 0; n_checks = 0; n_errors = 0; fin = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        sb_rd = sb_wr;
        chk("reset_outputs",
            64'({res_valid, res_id, res_quotient, res_remainder, res_div_by_zero, busy, req_ready}),
            64'd0);
      end else begin
        g = pick();
        exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        exp_busy = 1'b0;
        for (int i = 0; i < NR; i++) if (m_infl[i] != 0) exp_busy = 1'b1;
        chk("busy", 64'(busy), 64'(exp_busy));
        exp_v = (sb_rd != sb_wr) && (sb_due[sb_rd % SBD] == cyc);
        if (exp_v || res_valid) begin
          chk("res_valid", 64'(res_valid), 64'(exp_v));
          if (exp_v && res_valid) begin
            chk("res_id", 64'(res_id), 64'(sb_id[sb_rd % SBD]));
            chk("res_quotient", 64'(res_quotient), 64'(sb_q[sb_rd % SBD]));
            chk("res_remainder", 64'(res_remainder), 64'(sb_r[sb_rd % SBD]));
            chk("res_div_by_zero", 64'(res_div_by_zero), 64'(sb_dbz[sb_rd % SBD]));
          end
          if (exp_v) sb_rd++;
        end
      end
      if (done && !fin) begin
        chk("results_drained", 64'(sb_wr - sb_rd), 64'd0);
        fin = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [NW-1:0] num, input logic [DW-1:0] den,
                        input logic [NW-1:0] q, input logic [NW-1:0] r, input logic dbz);
    req_numerator[i*NW +: NW]   = num;
    req_denominator[i*DW +: DW] = den;
    op_q[i]   = q;
    op_r[i]   = r;
    op_dbz[i] = dbz;
  endtask

  task automatic set_rr_ops();
    set_op(0, 24'd100, 20'd10, 24'd10, 24'd0, 1'b0);
    set_op(1, 24'd12345, 20'd100, 24'd123, 24'd45, 1'b0);
    set_op(2, 24'd1000, 20'd7, 24'd142, 24'd6, 1'b0);
    set_op(3, 24'hFFFFFF, 20'hFFFFF, 24'd16, 24'd15, 1'b0);
  endtask

  // Directed stimulus.
  initial begin
    resetb = 1'b0; issue_en = 1'b1; req_valid = '0; done = 1'b0;
    req_numerator = '0; req_denominator = '0;
    for (int i = 0; i < NR; i++) begin
      op_q[i] = '0; op_r[i] = '0; op_dbz[i] = 1'b0;
    end
    step(3);
    resetb = 1'b1;

    // Single request: 1000/7 from requester 2.
    set_op(2, 24'd1000, 20'd7, 24'd142, 24'd6, 1'b0);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(30);

    // Round-robin with all four requesters pending.
    set_rr_ops();
    req_valid = 4'b1111;
    step(12);
    req_valid = '0;
    step(30);

    // Credit limit: requester 1 alone, continuously.
    set_op(1, 24'd999999, 20'd1000, 24'd999, 24'd999, 1'b0);
    req_valid = 4'b0010;
    step(60);
    req_valid = '0;
    step(30);

    // Divide by zero from requester 0.
    set_op(0, 24'hABCDEF, 20'd0, 24'hFFFFFF, 24'hABCDEF, 1'b1);
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(30);

    // Reset with ten operations in flight, then a fresh request.
    set_rr_ops();
    req_valid = 4'b1111;
    step(10);
    req_valid = '0;
    resetb = 1'b0;
    step(3);
    resetb = 1'b1;
    set_op(2, 24'd1000, 20'd7, 24'd142, 24'd6, 1'b0);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(30);

    // issue_en gating: two grants, five blocked cycles, then resume at the held pointer.
    set_rr_ops();
    req_valid = 4'b1111;
    step(2);
    issue_en = 1'b0;
    step(5);
    issue_en = 1'b1;
    step(4);
    req_valid = '0;
    step(35);

    done = 1'b1;
    for (int k = 0; k < 5 && !fin; k++) @(posedge clk);
    if (!fin) begin
      $display("FAIL final_check: monitor did not complete the drain check");
      $fatal(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
